// File: rtl/lif_neuron_bank_if.sv
// Step handshake, configuration and result bus for the LIF neuron bank.
// The controller side is the master; the neuron bank is the slave.
interface lif_neuron_bank_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  logic                    start;
  logic [N_CH*WIDTH-1:0]   w_in;
  logic [WIDTH-1:0]        thr;
  logic                    mode;
  logic                    clear;
  logic                    ready;
  logic                    done;
  logic [N_CH-1:0]         spikes;
  logic [N_CH*WIDTH-1:0]   vm_flat;

  modport master (
    output start, w_in, thr, mode, clear,
    input  ready, done, spikes, vm_flat
  );

  modport slave (
    input  start, w_in, thr, mode, clear,
    output ready, done, spikes, vm_flat
  );
endinterface

// File: rtl/lif_neuron_bank.sv
// Bank of N_CH leaky integrate-and-fire neurons, one channel updated per cycle
// through a shared datapath; one start pulse runs a full step over all channels.
//
// state | meaning
// IDLE  | ready; accepts clear (priority) or start
// RUN   | updates channel idx, one per cycle
// DONE  | publishes spikes with a one-cycle done pulse
module lif_neuron_bank #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  lif_neuron_bank_if.slave bus
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [WIDTH-1:0]      vm   [N_CH];
  logic [RW-1:0]         refr [N_CH];
  logic [N_CH*WIDTH-1:0] w_lat;
  logic [WIDTH-1:0]      thr_lat;
  logic                  mode_lat;
  logic [N_CH-1:0]       spk_acc;
  logic                  ready_q;
  logic                  done_q;
  logic [N_CH-1:0]       spikes_q;

  logic [WIDTH-1:0]      vm_cur;
  logic [WIDTH-1:0]      w_cur;
  logic [WIDTH-1:0]      leak;
  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        over;
  logic                  busy;
  logic                  fire;
  logic [WIDTH-1:0]      vm_next;
  logic [RW-1:0]         refr_next;

  // Shared update datapath for the channel selected by idx.
  always_comb begin
    vm_cur    = vm[idx];
    w_cur     = w_lat[int'(idx)*WIDTH +: WIDTH];
    leak      = (LEAK_SHIFT == 0) ? '0 : (vm_cur >> LEAK_SHIFT);
    sum       = {1'b0, vm_cur} - {1'b0, leak} + {1'b0, w_cur};
    over      = sum - {1'b0, thr_lat};
    busy      = (refr[idx] != '0);
    fire      = !busy && (sum >= {1'b0, thr_lat});
    vm_next   = sum[WIDTH-1:0];
    refr_next = '0;
    if (busy) begin
      vm_next   = '0;
      refr_next = refr[idx] - RW'(1);
    end else if (fire) begin
      refr_next = RW'(REFRACT);
      if (!mode_lat)
        vm_next = '0;
      else if (over[WIDTH])
        vm_next = '1;
      else
        vm_next = over[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      w_lat    <= '0;
      thr_lat  <= '0;
      mode_lat <= 1'b0;
      spk_acc  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      spikes_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        vm[k]   <= '0;
        refr[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            for (int k = 0; k < N_CH; k++) begin
              vm[k]   <= '0;
              refr[k] <= '0;
            end
          end else if (bus.start) begin
            w_lat    <= bus.w_in;
            thr_lat  <= bus.thr;
            mode_lat <= bus.mode;
            idx      <= '0;
            spk_acc  <= '0;
            ready_q  <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          vm[idx]      <= vm_next;
          refr[idx]    <= refr_next;
          spk_acc[idx] <= fire;
          if (idx == IW'(N_CH - 1))
            state <= DONE;
          else
            idx <= idx + IW'(1);
        end
        DONE: begin
          done_q   <= 1'b1;
          spikes_q <= spk_acc;
          ready_q  <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.spikes = spikes_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_vm
    assign bus.vm_flat[g*WIDTH +: WIDTH] = vm[g];
  end

endmodule

// File: tb/tb_lif_neuron_bank.sv
// Checks three neuron-bank configurations (leak/refractory variants) driven by
// shared stimulus against a per-configuration behavioural model.
module tb_lif_neuron_bank;
  localparam int N = 4;
  localparam int W = 8;
  localparam int VMAX = (1 << W) - 1;

  logic clk, rst;
  logic start, clear, mode;
  logic [N*W-1:0] w_in;
  logic [W-1:0] thr;

  int checks = 0;
  int failures = 0;

  // cfg0: LEAK_SHIFT=4 REFRACT=2, cfg1: no leak no refractory, cfg2: LEAK_SHIFT=1
  int lsh[3] = '{4, 0, 1};
  int rfr[3] = '{2, 0, 0};
  int mvm[3][N];
  int mrefr[3][N];
  logic [N-1:0] mspk[3];

  lif_neuron_bank_if #(.N_CH(N), .WIDTH(W)) if0 ();
  lif_neuron_bank_if #(.N_CH(N), .WIDTH(W)) if1 ();
  lif_neuron_bank_if #(.N_CH(N), .WIDTH(W)) if2 ();

  assign if0.start = start; assign if0.clear = clear; assign if0.mode = mode;
  assign if0.w_in = w_in;   assign if0.thr = thr;
  assign if1.start = start; assign if1.clear = clear; assign if1.mode = mode;
  assign if1.w_in = w_in;   assign if1.thr = thr;
  assign if2.start = start; assign if2.clear = clear; assign if2.mode = mode;
  assign if2.w_in = w_in;   assign if2.thr = thr;

  lif_neuron_bank #(.N_CH(N), .WIDTH(W), .LEAK_SHIFT(4), .REFRACT(2))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  lif_neuron_bank #(.N_CH(N), .WIDTH(W), .LEAK_SHIFT(0), .REFRACT(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  lif_neuron_bank #(.N_CH(N), .WIDTH(W), .LEAK_SHIFT(1), .REFRACT(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] obs_vm(input int c);
    case (c)
      0: return if0.vm_flat;
      1: return if1.vm_flat;
      default: return if2.vm_flat;
    endcase
  endfunction

  function automatic logic [N-1:0] obs_spk(input int c);
    case (c)
      0: return if0.spikes;
      1: return if1.spikes;
      default: return if2.spikes;
    endcase
  endfunction

  function automatic logic obs_done(input int c);
    case (c)
      0: return if0.done;
      1: return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic obs_ready(input int c);
    case (c)
      0: return if0.ready;
      1: return if1.ready;
      default: return if2.ready;
    endcase
  endfunction

  function automatic logic [N*W-1:0] exp_vm(input int c);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = mvm[c][k][W-1:0];
    return v;
  endfunction

  function automatic logic [N*W-1:0] splat(input int v);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v[W-1:0];
    return r;
  endfunction

  function automatic void model_zero();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < N; k++) begin
        mvm[c][k] = 0;
        mrefr[c][k] = 0;
      end
    end
  endfunction

  function automatic void model_step(input int c, input logic [N*W-1:0] w, input int t, input bit m);
    int wk, leak, sum;
    mspk[c] = '0;
    for (int k = 0; k < N; k++) begin
      wk = int'(w[k*W +: W]);
      if (mrefr[c][k] > 0) begin
        mrefr[c][k] = mrefr[c][k] - 1;
        mvm[c][k] = 0;
      end else begin
        leak = (lsh[c] == 0) ? 0 : (mvm[c][k] >> lsh[c]);
        sum = mvm[c][k] - leak + wk;
        if (sum >= t) begin
          mspk[c][k] = 1'b1;
          mrefr[c][k] = rfr[c];
          mvm[c][k] = m ? (((sum - t) > VMAX) ? VMAX : (sum - t)) : 0;
        end else begin
          mvm[c][k] = sum;
        end
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_done(c) !== 1'b1 || obs_spk(c) !== mspk[c] || obs_vm(c) !== exp_vm(c)) begin
        failures++;
        $display("FAIL %s cfg%0d done=%b spikes=%b vm=%h required done=1 spikes=%b vm=%h",
                 tag, c, obs_done(c), obs_spk(c), obs_vm(c), mspk[c], exp_vm(c));
      end
    end
  endtask

  task automatic run_step(input logic [N*W-1:0] w, input int t, input bit m);
    int n;
    @(negedge clk);
    checks++;
    if (obs_ready(0) !== 1'b1) begin
      failures++;
      $display("FAIL ready_idle got=%b required=1", obs_ready(0));
    end
    start = 1'b1; w_in = w; thr = t[W-1:0]; mode = m;
    @(negedge clk);
    start = 1'b0; w_in = {$urandom, $urandom}; thr = W'($urandom); mode = 1'($urandom);
    checks++;
    if (obs_ready(0) !== 1'b0) begin
      failures++;
      $display("FAIL ready_busy got=%b required=0", obs_ready(0));
    end
    n = 0;
    while (obs_done(0) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != N + 1) begin
      failures++;
      $display("FAIL latency got=%0d required=%0d", n, N + 1);
    end
    for (int c = 0; c < 3; c++) model_step(c, w, t, m);
    compare_all("step");
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_vm(c) !== '0) begin
        failures++;
        $display("FAIL clear cfg%0d vm=%h required=0", c, obs_vm(c));
      end
    end
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    bit bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (obs_done(0) !== 1'b0 || obs_ready(0) !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s got=unexpected done or busy required=quiet idle", tag);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_ready(c) !== 1'b1 || obs_done(c) !== 1'b0 || obs_spk(c) !== '0 || obs_vm(c) !== '0) begin
        failures++;
        $display("FAIL %s cfg%0d ready=%b done=%b spikes=%b vm=%h required 1/0/0/0",
                 tag, c, obs_ready(c), obs_done(c), obs_spk(c), obs_vm(c));
      end
    end
  endtask

  task automatic test_reset();
    check_reset_values("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_release");
    // Abort a step mid-RUN: outputs must clear without a clock edge.
    run_step(splat(200), 10, 1'b1);
    @(negedge clk);
    start = 1'b1; w_in = splat(33); thr = 8'd5; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_values("reset_async");
    @(negedge clk);
    rst = 1'b0;
    model_zero();
    for (int c = 0; c < 3; c++) mspk[c] = '0;
    check_quiet("reset_no_done", 10);
  endtask

  task automatic test_divider();
    int exp_v[7] = '{30, 60, 90, 20, 50, 80, 10};
    logic [6:0] exp_s = 7'b1001000;
    logic [N*W-1:0] v;
    logic [N-1:0] s;
    pulse_clear();
    for (int i = 0; i < 7; i++) begin
      run_step({24'd0, 8'd30}, 100, 1'b1);
      v = obs_vm(1);
      s = obs_spk(1);
      checks++;
      if (v[7:0] !== exp_v[i][7:0] || s[0] !== exp_s[i]) begin
        failures++;
        $display("FAIL divider step%0d vm=%0d spike=%b required vm=%0d spike=%b",
                 i + 1, v[7:0], s[0], exp_v[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_refractory();
    int exp_v[6] = '{60, 0, 0, 0, 60, 0};
    logic [5:0] exp_s = 6'b100010;
    logic [N*W-1:0] v;
    logic [N-1:0] s;
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      run_step(splat(60), 100, 1'b0);
      v = obs_vm(0);
      s = obs_spk(0);
      checks++;
      if (v !== splat(exp_v[i]) || s !== {N{exp_s[i]}}) begin
        failures++;
        $display("FAIL refractory step%0d vm=%h spikes=%b required vm=%h spikes=%b",
                 i + 1, v, s, splat(exp_v[i]), {N{exp_s[i]}});
      end
    end
  endtask

  task automatic test_leak();
    int exp_v[4] = '{40, 20, 10, 5};
    pulse_clear();
    run_step(splat(80), 200, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_step('0, 200, 1'b0);
      checks++;
      if (obs_vm(2) !== splat(exp_v[i]) || obs_spk(2) !== '0 || obs_vm(1) !== splat(80)) begin
        failures++;
        $display("FAIL leak step%0d vm_leak=%h spikes=%b vm_noleak=%h required %h 0 %h",
                 i + 1, obs_vm(2), obs_spk(2), obs_vm(1), splat(exp_v[i]), splat(80));
      end
    end
  endtask

  task automatic test_saturation();
    pulse_clear();
    run_step(splat(255), 0, 1'b1);
    run_step(splat(255), 1, 1'b1);
    checks++;
    if (obs_vm(1) !== splat(255) || obs_spk(1) !== 4'b1111) begin
      failures++;
      $display("FAIL saturation vm=%h spikes=%b required vm=%h spikes=1111",
               obs_vm(1), obs_spk(1), splat(255));
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [N*W-1:0] w;
    pulse_clear();
    w = {8'd20, 8'd45, 8'd7, 8'd90};
    @(negedge clk);
    start = 1'b1; w_in = w; thr = 8'd50; mode = 1'b1;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (obs_done(0) !== 1'b1 && n < 20);
      checks++;
      if (n != N + 2) begin
        failures++;
        $display("FAIL b2b_period%0d got=%0d required=%0d", p, n, N + 2);
      end
      for (int c = 0; c < 3; c++) model_step(c, w, 50, 1'b1);
      compare_all("b2b");
    end
    start = 1'b0;
    check_quiet("b2b_stop", 8);
  endtask

  task automatic test_start_in_run();
    int n;
    logic [N*W-1:0] w;
    w = {8'd11, 8'd120, 8'd64, 8'd3};
    @(negedge clk);
    start = 1'b1; w_in = w; thr = 8'd70; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; w_in = splat(255); thr = 8'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (obs_done(0) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 3; c++) model_step(c, w, 70, 1'b0);
    compare_all("start_in_run");
    check_quiet("start_in_run_ignored", 10);
  endtask

  task automatic test_clear_start();
    run_step(splat(50), 255, 1'b0);
    @(negedge clk);
    clear = 1'b1; start = 1'b1; w_in = splat(9); thr = 8'd0;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    model_zero();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_vm(c) !== '0) begin
        failures++;
        $display("FAIL clear_start cfg%0d vm=%h required=0", c, obs_vm(c));
      end
    end
    check_quiet("clear_start_no_step", 8);
  endtask

  task automatic test_thr_zero();
    pulse_clear();
    run_step({$urandom}, 0, 1'($urandom));
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs_spk(c) !== 4'b1111) begin
        failures++;
        $display("FAIL thr_zero cfg%0d spikes=%b required=1111", c, obs_spk(c));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_clear();
      run_step({$urandom}, int'($urandom_range(0, 255)), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; mode = 1'b0; w_in = '0; thr = '0;
    model_zero();
    for (int c = 0; c < 3; c++) mspk[c] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_divider();
    test_refractory();
    test_leak();
    test_saturation();
    test_back_to_back();
    test_start_in_run();
    test_clear_start();
    test_thr_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
